// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch control, FSM states, Mem_Ctrl fields.
package ex_pkg;
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_LUI   = 4'd10;
    localparam logic [3:0] ALU_AUIPC = 4'd11;
    localparam logic [3:0] ALU_MUL   = 4'd12;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_COND = 2'd1;
    localparam logic [1:0] BR_JAL  = 2'd2;
    localparam logic [1:0] BR_JALR = 2'd3;

    typedef enum logic [2:0] {
        s_WT  = 3'b001,
        s_MUL = 3'b010,
        s_HLD = 3'b100
    } ex_state_t;

    localparam int MC_MEMW = 5;
    localparam int MC_MEMR = 4;
endpackage

// File: rtl/ex_alu.sv
// Combinational ALU plus branch comparator and redirect target.
// Zero latency; no state, no backpressure.
module ex_alu
    import ex_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic [31:0] i_imm,
    input  logic        i_use_imm,
    input  logic [3:0]  i_alu_op,
    input  logic [1:0]  i_br_ctrl,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_alu_res,
    output logic        o_redirect,
    output logic [31:0] o_target
);
    logic [31:0] w_b;
    logic [4:0]  w_shamt;
    logic        w_eq;
    logic        w_lt;
    logic        w_ltu;
    logic        w_taken;

    assign w_b     = i_use_imm ? i_imm : i_op_b;
    assign w_shamt = w_b[4:0];

    always_comb begin
        o_alu_res = 32'd0;
        case (i_alu_op)
            ALU_ADD:   o_alu_res = i_op_a + w_b;
            ALU_SUB:   o_alu_res = i_op_a - w_b;
            ALU_SLL:   o_alu_res = i_op_a << w_shamt;
            ALU_SLT:   o_alu_res = {31'd0, $signed(i_op_a) < $signed(w_b)};
            ALU_SLTU:  o_alu_res = {31'd0, i_op_a < w_b};
            ALU_XOR:   o_alu_res = i_op_a ^ w_b;
            ALU_SRL:   o_alu_res = i_op_a >> w_shamt;
            ALU_SRA:   o_alu_res = 32'($signed(i_op_a) >>> w_shamt);
            ALU_OR:    o_alu_res = i_op_a | w_b;
            ALU_AND:   o_alu_res = i_op_a & w_b;
            ALU_LUI:   o_alu_res = w_b;
            ALU_AUIPC: o_alu_res = i_pc + w_b;
            default:   o_alu_res = 32'd0;
        endcase
    end

    // Branches always compare the register operands, never the immediate.
    assign w_eq  = (i_op_a == i_op_b);
    assign w_lt  = ($signed(i_op_a) < $signed(i_op_b));
    assign w_ltu = (i_op_a < i_op_b);

    always_comb begin
        w_taken = 1'b0;
        case (i_funct3)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = !w_eq;
            3'b100:  w_taken = w_lt;
            3'b101:  w_taken = !w_lt;
            3'b110:  w_taken = w_ltu;
            3'b111:  w_taken = !w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    assign o_redirect = ((i_br_ctrl == BR_COND) && w_taken) ||
                        (i_br_ctrl == BR_JAL) || (i_br_ctrl == BR_JALR);
    assign o_target   = (i_br_ctrl == BR_JALR) ? ((i_op_a + i_imm) & ~32'd1)
                                               : (i_pc + i_imm);
endmodule

// File: rtl/stage_ex.sv
// RV32 execute stage: ALU/address/store alignment, one-cycle fetch redirect, optional MUL_EN iterative multiplier.
// Latency 1 cycle (33 for MUL under MUL_EN); result held in s_HLD until Next_Ready, Done_I ignored unless idle.
module stage_ex
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_I,
    input  logic        Done_I,
    input  logic [31:0] Op_A,
    input  logic [31:0] Op_B,
    input  logic [31:0] Imm,
    input  logic        Use_Imm,
    input  logic [3:0]  ALU_Op,
    input  logic [1:0]  Br_Ctrl,
    input  logic        MemR_I,
    input  logic        MemW_I,
    input  logic [2:0]  Funct3,
    input  logic [4:0]  RF_waddr,
    input  logic        Next_Ready,
    output logic        Ready_O,
    output logic [31:0] PC_O,
    output logic        Done_O,
    output logic [31:0] Result,
    output logic [5:0]  Mem_Ctrl,
    output logic [31:0] Mem_wdata,
    output logic [4:0]  RF_waddr_O,
    output logic [2:0]  Funct3_O,
    output logic        Redirect_Valid,
    output logic [31:0] Redirect_PC
);
    ex_state_t   r_state;
    logic [31:0] r_pc, r_result, r_wdata, r_redir_pc;
    logic [5:0]  r_mem_ctrl;
    logic [4:0]  r_waddr;
    logic [2:0]  r_funct3;
    logic        r_redir_vld;

    logic [31:0] w_alu_res, w_target, w_addr, w_result, w_wdata;
    logic        w_redirect;
    logic [3:0]  w_strb;
    logic [5:0]  w_mem_ctrl;

`ifdef MUL_EN
    logic [63:0] r_acc, r_mcand;
    logic [31:0] r_mplier;
    logic [4:0]  r_cnt;
    logic [63:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
`endif

    ex_alu u_alu (
        .i_pc       (PC_I),
        .i_op_a     (Op_A),
        .i_op_b     (Op_B),
        .i_imm      (Imm),
        .i_use_imm  (Use_Imm),
        .i_alu_op   (ALU_Op),
        .i_br_ctrl  (Br_Ctrl),
        .i_funct3   (Funct3),
        .o_alu_res  (w_alu_res),
        .o_redirect (w_redirect),
        .o_target   (w_target)
    );

    assign w_addr = Op_A + Imm;

    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = 32'd0;
        case (Funct3[1:0])
            2'b00:   begin w_strb = 4'b0001 << w_addr[1:0];            w_wdata = {4{Op_B[7:0]}};  end
            2'b01:   begin w_strb = w_addr[1] ? 4'b1100 : 4'b0011;     w_wdata = {2{Op_B[15:0]}}; end
            default: begin w_strb = 4'b1111;                           w_wdata = Op_B;            end
        endcase
        w_mem_ctrl = 6'd0;
        if (MemW_I) begin
            w_mem_ctrl[MC_MEMW] = 1'b1;
            w_mem_ctrl[3:0]     = w_strb;
        end else if (MemR_I) begin
            w_mem_ctrl[MC_MEMR] = 1'b1;
        end
        if (!MemW_I) w_wdata = 32'd0;
        if (MemR_I || MemW_I)
            w_result = w_addr;
        else if (Br_Ctrl == BR_JAL || Br_Ctrl == BR_JALR)
            w_result = PC_I + 32'd4;
        else
            w_result = w_alu_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= s_WT;
            r_pc        <= 32'd0;
            r_result    <= 32'd0;
            r_wdata     <= 32'd0;
            r_mem_ctrl  <= 6'd0;
            r_waddr     <= 5'd0;
            r_funct3    <= 3'd0;
            r_redir_vld <= 1'b0;
            r_redir_pc  <= 32'd0;
`ifdef MUL_EN
            r_acc       <= 64'd0;
            r_mcand     <= 64'd0;
            r_mplier    <= 32'd0;
            r_cnt       <= 5'd0;
`endif
        end else begin
            // Redirect is a single pulse tied to acceptance, not to the hold.
            r_redir_vld <= 1'b0;
            case (r_state)
                s_WT: begin
                    if (Done_I) begin
                        r_pc        <= PC_I;
                        r_result    <= w_result;
                        r_wdata     <= w_wdata;
                        r_mem_ctrl  <= w_mem_ctrl;
                        r_waddr     <= RF_waddr;
                        r_funct3    <= Funct3;
                        r_redir_vld <= w_redirect;
                        r_redir_pc  <= w_target;
`ifdef MUL_EN
                        if (ALU_Op == ALU_MUL) begin
                            r_acc    <= 64'd0;
                            r_mcand  <= {32'd0, Op_A};
                            r_mplier <= Op_B;
                            r_cnt    <= 5'd0;
                            r_state  <= s_MUL;
                        end else
`endif
                        r_state <= s_HLD;
                    end
                end
`ifdef MUL_EN
                s_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_result <= w_acc_nxt[31:0];
                        r_state  <= s_HLD;
                    end
                end
`endif
                s_HLD: begin
                    if (Next_Ready) r_state <= s_WT;
                end
                default: r_state <= s_WT;
            endcase
        end
    end

    assign Ready_O        = (r_state == s_WT);
    assign Done_O         = (r_state == s_HLD);
    assign PC_O           = r_pc;
    assign Result         = r_result;
    assign Mem_Ctrl       = r_mem_ctrl;
    assign Mem_wdata      = r_wdata;
    assign RF_waddr_O     = r_waddr;
    assign Funct3_O       = r_funct3;
    assign Redirect_Valid = r_redir_vld;
    assign Redirect_PC    = r_redir_pc;
endmodule
